event_fifo_arbiter: RTL and testbench
=====================================

# event_fifo_arbiter

Round-robin write arbiter that shares the single load port of the pointer-based event FIFO among NCHAN transition-capture channels. Each channel delivers events as single-cycle strobes into a one-deep holding register. The arbiter grants one pending channel per cycle while the FIFO is not full and tags each FIFO word with the channel number and an overflow marker. It also counts events that were dropped because a channel's holding register was still occupied.

## Interface

Parameters:
- NCHAN, 4: number of requesting channels, 2..128.
- DWIDTH, 56: event payload width per channel.
- Derived, not overridable: FIFO word width = DWIDTH+8. This gives 64 at the default, matching the FIFO default WIDTH.

Ports:
- clk  in  1  system clock; all state changes on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- ev_stb  in  NCHAN  per-channel event strobe, one cycle per event.
- ev_data  in  NCHAN*DWIDTH  per-channel payload; channel k occupies bits [k*DWIDTH +: DWIDTH].
- fifo_full  in  1  full flag from the event FIFO.
- fifo_loaden  out  1  FIFO load enable (combinational).
- fifo_datain  out  DWIDTH+8  FIFO write word (combinational mux of holding registers).
- grant  out  NCHAN  one-hot; marks the channel written this cycle.
- ovf_flags  out  NCHAN  sticky per-channel drop flags.
- drop_count  out  16  total dropped events, saturating.
- clr_ovf  in  1  synchronous clear of ovf_flags and drop_count.

## Operation

- Per-channel state: hold_valid, hold_data[DWIDTH], ovf_mark.
- Capture:
  - ev_stb[k] high → hold_data[k] ← ev_data slice and hold_valid[k] ← 1.
  - This applies if hold_valid[k] is 0, or if channel k is granted in the same cycle (the simultaneous grant and new strobe refill the register; nothing is dropped).
- Drop:
  - Occurs when ev_stb[k] is high, hold_valid[k] is 1 and channel k is not granted this cycle.
  - The new event is discarded and hold_data is unchanged.
  - ovf_flags[k] ← 1, ovf_mark[k] ← 1, drop_count increments, saturating at 0xFFFF.
  - Multiple channels dropping in one cycle add their count, still saturating.
- Arbitration (combinational):
  - Candidate set = hold_valid.
  - Search starts at index rr_ptr and wraps past NCHAN-1 to 0; the first valid index wins.
  - fifo_loaden = (|hold_valid) & ~fifo_full.
  - grant is the winner's one-hot when fifo_loaden is 1, otherwise all zero.
- On a grant to channel k:
  - hold_valid[k] ← 0, unless refilled in the same cycle.
  - ovf_mark[k] ← 0.
  - rr_ptr ← (k+1) mod NCHAN.
  - With no grant, rr_ptr holds.
- Word format:
  - fifo_datain = {ovf_mark[k], chan[6:0], hold_data[k]}.
  - chan is the zero-extended winner index.
  - With no grant, fifo_datain is all zeros.
- ovf_mark signals that at least one event on channel k was lost before this word.
- clr_ovf:
  - Clears ovf_flags and drop_count.
  - A drop in the same cycle takes priority: the flag is set and drop_count becomes 1.
  - ovf_mark is not affected.
- fifo_full high blocks all grants. Holding registers keep their data, and subsequent strobes on occupied channels count as drops.

## Timing

- Reset values, asynchronous:
  - hold_valid = 0, ovf_mark = 0, rr_ptr = 0, ovf_flags = 0, drop_count = 0.
  - Hence fifo_loaden = 0, grant = 0, fifo_datain = 0.
- Latency: strobe at edge n → word eligible in cycle n+1 → written at edge n+1 if granted.
- Throughput:
  - One FIFO write per cycle aggregate.
  - A single channel can sustain a strobe every cycle only while it wins every cycle (sole active channel).
- fifo_full is sampled combinationally in the same cycle. The block never asserts fifo_loaden while fifo_full is 1, so the FIFO's internal load qualification never discards a granted word.
- Reset asserted mid-operation: pending events are discarded without a write, and rr_ptr returns to 0. FIFO contents are the FIFO's responsibility.
- Reset release: the first strobe is accepted at the first rising edge where rst is low.

## Test plan

- Single event: reset, then ev_stb[2]=1 with payload 0x123 for one cycle. Required next cycle: fifo_loaden=1, grant=0100, fifo_datain={0,7'd2,0x123}. Following cycle: fifo_loaden=0.
- Round-robin fairness: all 4 channels strobe at the same edge with rr_ptr=0. Required grants on consecutive cycles: 0,1,2,3. Then strobe ch0 and ch3 together: grant order 0 then 3 (rr_ptr=0 after wrap).
- Full back-pressure:
  - Hold fifo_full=1 and strobe ch1 twice, 2 cycles apart. Required: no fifo_loaden, drop_count=1, ovf_flags=0010.
  - Release fifo_full: one word {1,7'd1,first payload}.
  - Next ch1 event has ovf_mark=0.
- Grant/refill collision: ch0 strobes every cycle for 5 cycles with other channels idle. Required: 5 consecutive writes, drop_count=0.
- Saturation and clear:
  - Force 65540 drops. Required: drop_count=0xFFFF.
  - clr_ovf together with a new drop → drop_count=1 and the flag remains set.
  - clr_ovf alone → both cleared.
- Async reset mid-op: assert rst with 3 channels pending. Required: fifo_loaden and grant go to 0 immediately. After release, no stale words are written and the first grant is the lowest strobed channel.

Source files
------------

// File: rtl/event_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : event_fifo_arbiter
// Purpose  : Round-robin arbiter sharing one event-FIFO load port among
//            NCHAN transition-capture channels. Each channel owns a one-deep
//            holding register; collisions on an occupied register are
//            counted as drops and flagged per channel.
// Revision : 1.0 - initial release
// ============================================================================
module event_fifo_arbiter #(
  parameter int NCHAN  = 4,
  parameter int DWIDTH = 56
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NCHAN-1:0]        ev_stb,
  input  logic [NCHAN*DWIDTH-1:0] ev_data,
  input  logic                    fifo_full,
  output logic                    fifo_loaden,
  output logic [DWIDTH+7:0]       fifo_datain,
  output logic [NCHAN-1:0]        grant,
  output logic [NCHAN-1:0]        ovf_flags,
  output logic [15:0]             drop_count,
  input  logic                    clr_ovf
);

  // Pointer width; a 2-channel build still needs one bit.
  localparam int PW = (NCHAN > 1) ? $clog2(NCHAN) : 1;
  localparam int FW = DWIDTH + 8;

  // Constants sized to the arithmetic they take part in.
  localparam logic [PW:0]   C_NCHAN_W = (PW+1)'(NCHAN);
  localparam logic [PW-1:0] C_LAST    = PW'(NCHAN - 1);
  localparam logic [15:0]   C_SAT     = 16'hFFFF;

  // --------------------------------------------------------------------------
  // State
  // --------------------------------------------------------------------------
  logic [NCHAN-1:0]  hold_valid_q, hold_valid_d;
  logic [NCHAN-1:0]  ovf_mark_q,   ovf_mark_d;
  logic [NCHAN-1:0]  ovf_flags_q,  ovf_flags_d;
  logic [PW-1:0]     rr_ptr_q,     rr_ptr_d;
  logic [15:0]       drop_count_q, drop_count_d;
  logic [DWIDTH-1:0] hold_data_q [NCHAN];

  // --------------------------------------------------------------------------
  // Combinational helpers
  // --------------------------------------------------------------------------
  logic              w_win_found;
  logic [PW-1:0]     w_win_idx;
  logic              w_loaden;
  logic [NCHAN-1:0]  w_grant;
  logic [NCHAN-1:0]  w_drop;
  logic [NCHAN-1:0]  w_cap;
  logic [7:0]        w_ndrop;
  logic [6:0]        w_chan;
  logic [15:0]       w_cnt_base;
  logic [16:0]       w_cnt_sum;

  // Round-robin search: first valid holding register at or after rr_ptr, wrapping.
  always_comb begin : p_arb
    logic [PW:0] cand;
    w_win_found = 1'b0;
    w_win_idx   = '0;
    cand        = '0;
    for (int i = 0; i < NCHAN; i++) begin
      cand = {1'b0, rr_ptr_q} + (PW+1)'(i);
      if (cand >= C_NCHAN_W) begin
        cand = cand - C_NCHAN_W;
      end
      if (!w_win_found && hold_valid_q[cand[PW-1:0]]) begin
        w_win_found = 1'b1;
        w_win_idx   = cand[PW-1:0];
      end
    end
  end

  // A write happens only when something is pending and the FIFO has room.
  assign w_loaden = w_win_found & ~fifo_full;
  assign w_grant  = w_loaden ? (NCHAN'(1) << w_win_idx) : '0;
  assign w_chan   = 7'(w_win_idx);

  // Per-channel capture / drop decisions. A granted channel is vacated this
  // edge, so a fresh strobe on it refills the register rather than dropping.
  for (genvar k = 0; k < NCHAN; k++) begin : g_chan
    assign w_drop[k]       = ev_stb[k] & hold_valid_q[k] & ~w_grant[k];
    assign w_cap[k]        = ev_stb[k] & ~w_drop[k];
    assign hold_valid_d[k] = w_cap[k] | (hold_valid_q[k] & ~w_grant[k]);
    assign ovf_mark_d[k]   = w_drop[k] | (ovf_mark_q[k] & ~w_grant[k]);
  end

  // Number of channels dropping an event this cycle.
  always_comb begin : p_popcnt
    w_ndrop = '0;
    for (int k = 0; k < NCHAN; k++) begin
      w_ndrop = w_ndrop + 8'(w_drop[k]);
    end
  end

  // Next-state for pointer, sticky flags and saturating drop counter.
  // A clear coinciding with a drop keeps that cycle's drops.
  always_comb begin : p_next
    rr_ptr_d = rr_ptr_q;
    if (w_loaden) begin
      rr_ptr_d = (w_win_idx == C_LAST) ? '0 : (w_win_idx + PW'(1));
    end
    ovf_flags_d  = (clr_ovf ? '0 : ovf_flags_q) | w_drop;
    w_cnt_base   = clr_ovf ? 16'd0 : drop_count_q;
    w_cnt_sum    = {1'b0, w_cnt_base} + 17'(w_ndrop);
    drop_count_d = w_cnt_sum[16] ? C_SAT : w_cnt_sum[15:0];
  end

  // Control state with asynchronous reset; pending events vanish on reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      hold_valid_q <= '0;
      ovf_mark_q   <= '0;
      ovf_flags_q  <= '0;
      rr_ptr_q     <= '0;
      drop_count_q <= '0;
    end else begin
      hold_valid_q <= hold_valid_d;
      ovf_mark_q   <= ovf_mark_d;
      ovf_flags_q  <= ovf_flags_d;
      rr_ptr_q     <= rr_ptr_d;
      drop_count_q <= drop_count_d;
    end
  end

  // Payload registers need no reset: they are only read while hold_valid is set.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NCHAN; k++) begin
      if (w_cap[k]) begin
        hold_data_q[k] <= ev_data[k*DWIDTH +: DWIDTH];
      end
    end
  end

  // --------------------------------------------------------------------------
  // Outputs
  // --------------------------------------------------------------------------
  assign fifo_loaden = w_loaden;
  assign grant       = w_grant;
  assign fifo_datain = w_loaden ? {ovf_mark_q[w_win_idx], w_chan, hold_data_q[w_win_idx]}
                                : {FW{1'b0}};
  assign ovf_flags   = ovf_flags_q;
  assign drop_count  = drop_count_q;

endmodule
`default_nettype wire

// File: tb/tb_event_fifo_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_event_fifo_arbiter
// Purpose  : Directed plus randomized bench for event_fifo_arbiter against a
//            per-channel behavioural model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_event_fifo_arbiter;
  localparam int NCHAN  = 4;
  localparam int DWIDTH = 56;

  logic                    clk = 1'b0;
  logic                    rst = 1'b1;
  logic [NCHAN-1:0]        ev_stb = '0;
  logic [NCHAN*DWIDTH-1:0] ev_data = '0;
  logic                    fifo_full = 1'b0;
  logic                    clr_ovf = 1'b0;
  logic                    fifo_loaden;
  logic [DWIDTH+7:0]       fifo_datain;
  logic [NCHAN-1:0]        grant;
  logic [NCHAN-1:0]        ovf_flags;
  logic [15:0]             drop_count;

  event_fifo_arbiter #(.NCHAN(NCHAN), .DWIDTH(DWIDTH)) dut (
    .clk(clk), .rst(rst), .ev_stb(ev_stb), .ev_data(ev_data),
    .fifo_full(fifo_full), .fifo_loaden(fifo_loaden), .fifo_datain(fifo_datain),
    .grant(grant), .ovf_flags(ovf_flags), .drop_count(drop_count), .clr_ovf(clr_ovf)
  );

  always #5 clk = ~clk;

  int n_total = 0;
  int n_pass  = 0;
  int n_fail  = 0;

  // Behavioural model: one pending slot per channel, a rotating start index.
  bit              m_pend [NCHAN];
  logic [DWIDTH-1:0] m_data [NCHAN];
  bit              m_mark [NCHAN];
  int              m_rr;
  logic [NCHAN-1:0] m_flags;
  int              m_cnt;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NCHAN; k++) begin
      m_pend[k] = 0; m_mark[k] = 0; m_data[k] = '0;
    end
    m_rr = 0; m_flags = '0; m_cnt = 0;
  endtask

  task automatic set_payload(input int k, input logic [DWIDTH-1:0] d);
    ev_data[k*DWIDTH +: DWIDTH] = d;
  endtask

  // One clock: check outputs at the falling edge, advance model at the rising edge.
  task automatic cycle();
    int w;
    bit le;
    logic [63:0] eg, ed;
    int nd;
    @(negedge clk);
    w = -1;
    for (int i = 0; i < NCHAN; i++) begin
      int c;
      c = (m_rr + i) % NCHAN;
      if (w < 0 && m_pend[c]) w = c;
    end
    le = (w >= 0) && !fifo_full;
    eg = 64'd0; ed = 64'd0;
    if (le) begin
      eg = 64'd1 << w;
      ed = {m_mark[w], 7'(w), m_data[w]};
    end
    chk("loaden", 64'(fifo_loaden), 64'(le));
    chk("grant", 64'(grant), eg);
    chk("datain", fifo_datain, ed);
    chk("ovf_flags", 64'(ovf_flags), 64'(m_flags));
    chk("drop_count", 64'(drop_count), 64'(m_cnt));
    @(posedge clk);
    if (le) begin
      m_pend[w] = 0; m_mark[w] = 0; m_rr = (w + 1) % NCHAN;
    end
    if (clr_ovf) m_flags = '0;
    nd = 0;
    for (int k = 0; k < NCHAN; k++) begin
      if (ev_stb[k]) begin
        if (!m_pend[k]) begin
          m_pend[k] = 1; m_data[k] = ev_data[k*DWIDTH +: DWIDTH];
        end else begin
          nd++; m_flags[k] = 1'b1; m_mark[k] = 1;
        end
      end
    end
    m_cnt = (clr_ovf ? 0 : m_cnt) + nd;
    if (m_cnt > 65535) m_cnt = 65535;
    #1;
  endtask

  // Asynchronous reset pulse starting mid-cycle.
  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    chk("rst_loaden", 64'(fifo_loaden), 64'd0);
    chk("rst_grant", 64'(grant), 64'd0);
    chk("rst_datain", fifo_datain, 64'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int writes;
    logic [63:0] r;
    model_reset();
    // Reset state
    #2;
    chk("reset_loaden", 64'(fifo_loaden), 64'd0);
    chk("reset_grant", 64'(grant), 64'd0);
    chk("reset_datain", fifo_datain, 64'd0);
    chk("reset_flags", 64'(ovf_flags), 64'd0);
    chk("reset_count", 64'(drop_count), 64'd0);
    #10 rst = 1'b0;
    @(posedge clk); #1;

    // Single event on channel 2
    ev_stb = 4'b0100; set_payload(2, 56'h123);
    cycle();
    ev_stb = '0;
    chk("single_loaden", 64'(fifo_loaden), 64'd1);
    chk("single_grant", 64'(grant), 64'b0100);
    chk("single_datain", fifo_datain, {1'b0, 7'd2, 56'h123});
    cycle();
    chk("single_after", 64'(fifo_loaden), 64'd0);
    cycle();

    // Round-robin fairness from rr_ptr = 0
    do_reset();
    ev_stb = 4'b1111;
    for (int k = 0; k < NCHAN; k++) set_payload(k, 56'(32'hA0 + k));
    cycle();
    ev_stb = '0;
    for (int i = 0; i < NCHAN; i++) begin
      chk("rr_grant", 64'(grant), 64'd1 << i);
      cycle();
    end
    ev_stb = 4'b1001; set_payload(0, 56'hB0); set_payload(3, 56'hB3);
    cycle();
    ev_stb = '0;
    chk("rr_wrap0", 64'(grant), 64'b0001);
    cycle();
    chk("rr_wrap3", 64'(grant), 64'b1000);
    cycle();
    cycle();

    // Full back-pressure with a drop on channel 1
    fifo_full = 1'b1;
    ev_stb = 4'b0010; set_payload(1, 56'h111);
    cycle();
    ev_stb = '0;
    cycle(); cycle();
    ev_stb = 4'b0010; set_payload(1, 56'h222);
    cycle();
    ev_stb = '0;
    chk("bp_loaden", 64'(fifo_loaden), 64'd0);
    chk("bp_count", 64'(drop_count), 64'd1);
    chk("bp_flags", 64'(ovf_flags), 64'b0010);
    fifo_full = 1'b0;
    #1;
    chk("bp_release", fifo_datain, {1'b1, 7'd1, 56'h111});
    cycle();
    ev_stb = 4'b0010; set_payload(1, 56'h333);
    cycle();
    ev_stb = '0;
    chk("bp_next_mark", fifo_datain, {1'b0, 7'd1, 56'h333});
    cycle();

    // Grant/refill collision on channel 0
    clr_ovf = 1'b1;
    cycle();
    clr_ovf = 1'b0;
    writes = 0;
    for (int i = 0; i < 5; i++) begin
      ev_stb = 4'b0001; set_payload(0, 56'(i + 1));
      cycle();
      if (fifo_loaden) writes++;
    end
    ev_stb = '0;
    chk("refill_writes", 64'(writes), 64'd5);
    chk("refill_drops", 64'(drop_count), 64'd0);
    cycle();

    // Saturation: 4 drops per cycle for 16385 cycles = 65540 drops
    fifo_full = 1'b1;
    ev_stb = 4'b1111;
    cycle();
    for (int i = 0; i < 16385; i++) cycle();
    ev_stb = '0;
    chk("sat_count", 64'(drop_count), 64'hFFFF);
    clr_ovf = 1'b1; ev_stb = 4'b0001;
    cycle();
    chk("clr_drop_count", 64'(drop_count), 64'd1);
    chk("clr_drop_flag", 64'(ovf_flags), 64'b0001);
    ev_stb = '0;
    cycle();
    clr_ovf = 1'b0;
    chk("clr_count", 64'(drop_count), 64'd0);
    chk("clr_flags", 64'(ovf_flags), 64'd0);
    fifo_full = 1'b0;

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      for (int k = 0; k < NCHAN; k++) begin
        ev_stb[k] = ($urandom_range(0, 99) < 40);
        r = {$urandom(), $urandom()};
        set_payload(k, r[DWIDTH-1:0]);
      end
      fifo_full = ($urandom_range(0, 99) < 25);
      clr_ovf   = ($urandom_range(0, 99) < 3);
      cycle();
    end
    ev_stb = '0; fifo_full = 1'b0; clr_ovf = 1'b0;
    for (int i = 0; i < 8; i++) cycle();

    // Asynchronous reset with three channels pending
    fifo_full = 1'b1;
    ev_stb = 4'b0111;
    for (int k = 0; k < NCHAN; k++) set_payload(k, 56'(32'hC0 + k));
    cycle();
    ev_stb = '0; fifo_full = 1'b0;
    #1;
    chk("pre_rst_loaden", 64'(fifo_loaden), 64'd1);
    do_reset();
    cycle();
    ev_stb = 4'b1010; set_payload(1, 56'hD1); set_payload(3, 56'hD3);
    cycle();
    ev_stb = '0;
    chk("post_rst_grant", 64'(grant), 64'b0010);
    for (int i = 0; i < 3; i++) cycle();

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
